// File: rtl/dhm005_pkg.sv
// Shared widths, symbol constants and the count-saturation helper for dhm005.
package dhm005_pkg;

   localparam int unsigned SYM_W     = 2;
   localparam int unsigned N_SYM     = 8;
   localparam int unsigned CNT_W     = 3;
   localparam int unsigned INT_CNT_W = 4;

   localparam logic [SYM_W-1:0] SYM_0 = 2'b00;
   localparam logic [SYM_W-1:0] SYM_1 = 2'b01;
   localparam logic [SYM_W-1:0] SYM_2 = 2'b10;
   localparam logic [SYM_W-1:0] SYM_3 = 2'b11;

   localparam logic [INT_CNT_W-1:0] SAT_LIMIT = INT_CNT_W'(7);

   // Clamp a 0..8 internal count onto the 3-bit output range.
   function automatic logic [CNT_W-1:0] sat_cnt(input logic [INT_CNT_W-1:0] c);
      if (c > SAT_LIMIT) begin
         return CNT_W'(7);
      end
      return c[CNT_W-1:0];
   endfunction

endpackage

// File: rtl/dhm005_sym_count.sv
// Counts how many of the eight input symbols equal a given target value.
module dhm005_sym_count
   import dhm005_pkg::*;
(
   input  logic [N_SYM-1:0][SYM_W-1:0] sym_i,
   input  logic [SYM_W-1:0]            target_i,
   output logic [INT_CNT_W-1:0]        match_cnt_c_o
);

   // Combinational population count of matches.
   always_comb begin
      match_cnt_c_o = '0;
      for (int unsigned i = 0; i < N_SYM; i++) begin
         if (sym_i[i] == target_i) begin
            match_cnt_c_o = match_cnt_c_o + INT_CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/dhm005.sv
// Per-cycle symbol histogram: saturated counts per value and the most frequent
// value (lowest wins on ties), registered with one cycle of latency.
module dhm005
   import dhm005_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [SYM_W-1:0] data7,
   input  logic [SYM_W-1:0] data6,
   input  logic [SYM_W-1:0] data5,
   input  logic [SYM_W-1:0] data4,
   input  logic [SYM_W-1:0] data3,
   input  logic [SYM_W-1:0] data2,
   input  logic [SYM_W-1:0] data1,
   input  logic [SYM_W-1:0] data0,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1,
   output logic [CNT_W-1:0] cnt2,
   output logic [CNT_W-1:0] cnt3,
   output logic [SYM_W-1:0] max_data
);

   logic [N_SYM-1:0][SYM_W-1:0] sym;
   logic [3:0][INT_CNT_W-1:0]   raw_cnt;
   logic [3:0][CNT_W-1:0]       cnt_d, cnt_q;
   logic [SYM_W-1:0]            max_d, max_q;
   logic [INT_CNT_W-1:0]        best_cnt;

   assign sym = {data7, data6, data5, data4, data3, data2, data1, data0};

   dhm005_sym_count u_cnt0 (.sym_i(sym), .target_i(SYM_0), .match_cnt_c_o(raw_cnt[0]));
   dhm005_sym_count u_cnt1 (.sym_i(sym), .target_i(SYM_1), .match_cnt_c_o(raw_cnt[1]));
   dhm005_sym_count u_cnt2 (.sym_i(sym), .target_i(SYM_2), .match_cnt_c_o(raw_cnt[2]));
   dhm005_sym_count u_cnt3 (.sym_i(sym), .target_i(SYM_3), .match_cnt_c_o(raw_cnt[3]));

   // Saturate counts and pick the argmax on the unsaturated values; strict
   // greater-than keeps the lowest symbol when counts tie.
   always_comb begin
      cnt_d[0] = sat_cnt(raw_cnt[0]);
      cnt_d[1] = sat_cnt(raw_cnt[1]);
      cnt_d[2] = sat_cnt(raw_cnt[2]);
      cnt_d[3] = sat_cnt(raw_cnt[3]);
      best_cnt = raw_cnt[0];
      max_d    = SYM_0;
      if (raw_cnt[1] > best_cnt) begin
         best_cnt = raw_cnt[1];
         max_d    = SYM_1;
      end
      if (raw_cnt[2] > best_cnt) begin
         best_cnt = raw_cnt[2];
         max_d    = SYM_2;
      end
      if (raw_cnt[3] > best_cnt) begin
         best_cnt = raw_cnt[3];
         max_d    = SYM_3;
      end
   end

   // Output registers; reset clears results immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         max_q <= SYM_0;
      end else begin
         cnt_q <= cnt_d;
         max_q <= max_d;
      end
   end

   assign cnt0     = cnt_q[0];
   assign cnt1     = cnt_q[1];
   assign cnt2     = cnt_q[2];
   assign cnt3     = cnt_q[3];
   assign max_data = max_q;

endmodule

// File: tb/tb_dhm005.sv
// Bench for dhm005: reference histogram model checked every cycle, plus
// literal expectations for the directed vectors and the reset behaviour.
module tb_dhm005;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] vec = 16'h0000;   // {data7, ..., data0}
   logic [2:0]  cnt0, cnt1, cnt2, cnt3;
   logic [1:0]  max_data;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;
   logic [13:0] exp_q = 14'h0;    // {cnt0, cnt1, cnt2, cnt3, max_data}

   always #5 clk = ~clk;

   dhm005 dut (
      .clk(clk), .rst(rst),
      .data7(vec[15:14]), .data6(vec[13:12]), .data5(vec[11:10]), .data4(vec[9:8]),
      .data3(vec[7:6]),   .data2(vec[5:4]),   .data1(vec[3:2]),   .data0(vec[1:0]),
      .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3), .max_data(max_data)
   );

   // Histogram of the eight symbols, capped counts, first value reaching the peak.
   function automatic logic [13:0] model(input logic [15:0] v);
      int n[4];
      int peak;
      int mx;
      logic [2:0] c[4];
      for (int k = 0; k < 4; k++) n[k] = 0;
      for (int i = 0; i < 8; i++) n[int'(v[2*i +: 2])] += 1;
      peak = 0;
      for (int k = 0; k < 4; k++) if (n[k] > peak) peak = n[k];
      mx = -1;
      for (int k = 0; k < 4; k++) if (mx < 0 && n[k] == peak) mx = k;
      for (int k = 0; k < 4; k++) c[k] = 3'((n[k] > 7) ? 7 : n[k]);
      return {c[0], c[1], c[2], c[3], 2'(mx)};
   endfunction

   function automatic logic [13:0] dut_out();
      return {cnt0, cnt1, cnt2, cnt3, max_data};
   endfunction

   // Expected output tracks the registered behaviour of the model.
   always @(posedge clk or posedge rst) begin
      if (rst) exp_q = 14'h0;
      else     exp_q = model(vec);
   end

   // Every-cycle comparison on the falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         checks++;
         if (dut_out() !== exp_q) begin
            errors++;
            $display("FAIL model_cmp t=%0t vec=%h got=%b want=%b", $time, vec, dut_out(), exp_q);
         end
      end
   end

   task automatic check_lit(input string name, input logic [13:0] want);
      checks++;
      if (dut_out() !== want) begin
         errors++;
         $display("FAIL %s got cnt0..3=%0d,%0d,%0d,%0d max=%b want=%0d,%0d,%0d,%0d max=%b",
                  name, cnt0, cnt1, cnt2, cnt3, max_data,
                  want[13:11], want[10:8], want[7:5], want[4:2], want[1:0]);
      end
   endtask

   // Present a vector just after a falling edge, then check it one edge later.
   task automatic apply(input logic [15:0] v, input string name, input logic [13:0] want);
      @(negedge clk);
      #1 vec = v;
      @(negedge clk);
      #1 check_lit(name, want);
   endtask

   initial begin
      vec = 16'b10_10_11_01_00_10_01_10;
      #1 check_lit("reset_hold", 14'h0);
      chk_en = 1'b1;
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;

      // Directed vectors with hand-computed results.
      apply(16'b10_10_11_01_00_10_01_10, "vec_mix",   {3'd1, 3'd2, 3'd4, 3'd1, 2'b10});
      apply(16'b10_10_10_10_10_10_10_00, "vec_seven", {3'd1, 3'd0, 3'd7, 3'd0, 2'b10});
      apply(16'b11_10_11_10_11_10_11_00, "vec_four3", {3'd1, 3'd0, 3'd3, 3'd4, 2'b11});
      apply(16'b00_10_00_00_11_10_11_00, "vec_four0", {3'd4, 3'd0, 3'd2, 3'd2, 2'b00});
      apply(16'hFFFF,                    "all_ones",  {3'd0, 3'd0, 3'd0, 3'd7, 2'b11});
      apply(16'h7777,                    "tie_1_3",   {3'd0, 3'd4, 3'd0, 3'd4, 2'b01});
      apply(16'h0000,                    "all_zero",  {3'd7, 3'd0, 3'd0, 3'd0, 2'b00});
      apply(16'b01_10_01_10_00_00_11_11, "tie_2222",  {3'd2, 3'd2, 3'd2, 3'd2, 2'b00});
      apply(16'b10_11_10_11_10_11_10_11, "tie_2_3",   {3'd0, 3'd0, 3'd4, 3'd4, 2'b10});

      // Back-to-back random sets, checked by the model every cycle.
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         #1 vec = 16'($urandom);
      end

      // Asynchronous reset mid-stream with nonzero outputs.
      apply(16'b11_10_11_10_11_10_11_00, "pre_reset", {3'd1, 3'd0, 3'd3, 3'd4, 2'b11});
      @(posedge clk);
      #2 rst = 1'b1;
      #1 check_lit("async_clear", 14'h0);
      @(negedge clk);
      #1 vec = 16'h5555;
      rst = 1'b0;
      @(negedge clk);
      #1 check_lit("post_reset", {3'd0, 3'd7, 3'd0, 3'd0, 2'b01});

      @(negedge clk);
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
